// File: rtl/track_generator.sv
// track_generator: scrolling 3-lane platform window fed by a filtered LFSR.
// Column 0 of the window is the player column and drives `lines`. New
// columns enter at column DEPTH-1. Every generated pattern shares at least
// one lane with the previous one, so the player always has somewhere to go.
module track_generator #(
  parameter int          SCROLL_DIV = 4000,
  parameter int          DEPTH      = 16,
  parameter int          MIN_SEG    = 4,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          SCORE_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 is_dead,
  output logic [2:0]           lines,
  output logic [3*DEPTH-1:0]   track_window,
  output logic                 col_tick,
  output logic [SCORE_W-1:0]   score
);

  // Wide enough for MIN_SEG-1+15, the longest segment countdown.
  localparam int                SEG_W     = $clog2(MIN_SEG + 16);
  localparam logic [19:0]       PRESC_MAX = 20'(SCROLL_DIV - 1);
  localparam logic [SEG_W-1:0]  SEG_BASE  = SEG_W'(MIN_SEG - 1);

  logic [19:0]          presc_q, presc_d;
  logic                 tick_q, tick_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [SEG_W-1:0]     seg_q, seg_d;
  logic [2:0]           prev_q, prev_d;
  logic [3*DEPTH-1:0]   win_q, win_d;

  logic                 active, shift;
  logic [2:0]           cand, new_col;
  logic [SEG_W-1:0]     seg_len;

  assign active = run & ~is_dead;
  assign shift  = active && (presc_q == PRESC_MAX);

  // Candidate pattern: never empty, and forced fully open when it would
  // leave no lane in common with the pattern it follows.
  always_comb begin
    cand = lfsr_q[2:0];
    if (cand == 3'b000)          cand = 3'b111;
    if ((cand & prev_q) == 3'b000) cand = 3'b111;
    seg_len = SEG_BASE + SEG_W'(lfsr_q[6:3]);
  end

  // Next-state: everything holds unless active; the window, LFSR, segment
  // counter and score only move on the prescaler wrap cycle.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    score_d = score_q;
    lfsr_d  = lfsr_q;
    seg_d   = seg_q;
    prev_d  = prev_q;
    win_d   = win_q;
    new_col = prev_q;
    if (active) presc_d = shift ? 20'd0 : presc_q + 20'd1;
    if (shift) begin
      tick_d = 1'b1;
      if (seg_q != '0) begin
        new_col = prev_q;
        seg_d   = seg_q - SEG_W'(1);
      end else begin
        new_col = cand;
        prev_d  = cand;
        seg_d   = seg_len;
      end
      win_d   = {new_col, win_q[3*DEPTH-1:3]};
      lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      score_d = (&score_q) ? score_q : score_q + SCORE_W'(1);
    end
  end

  // State registers; reset takes effect immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      score_q <= '0;
      lfsr_q  <= SEED;
      seg_q   <= '0;
      prev_q  <= 3'b111;
      win_q   <= '1;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      score_q <= score_d;
      lfsr_q  <= lfsr_d;
      seg_q   <= seg_d;
      prev_q  <= prev_d;
      win_q   <= win_d;
    end
  end

  assign lines        = win_q[2:0];
  assign track_window = win_q;
  assign col_tick     = tick_q;
  assign score        = score_q;

endmodule
